dequant_engine: RTL

DEQUANT_ENGINE -- requirements
Module: dequant_engine

---
 rtl/dequant_engine.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dequant_engine.sv
// Column-wise coefficient dequantiser: each column is scaled by a per-bank
// 8x8 quantisation table, with a single registered valid/ready output stage.
// Optional DEQUANT_SAT_EN macro: clamp products to the OUT_W signed range
// instead of truncating them to the low OUT_W bits.
// Ports:
//   clk_in, rst_n_in                 clock, async active-low reset
//   column_in, valid_in, ready_out   input column handshake
//   bank_sel_in                      table bank, sampled on column 0
//   column_out, valid_out, ready_in  output column handshake
//   last_out                         marks column 7 of a block
//   tbl_wr_*_in, tbl_wr_err_out      table write port and reject pulse
module dequant_engine #(
    parameter int COEF_W = 12,
    parameter int OUT_W  = 16,
    parameter int NBANK  = 2,
    localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [8*COEF_W-1:0]   column_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [BW-1:0]         bank_sel_in,
    output logic [8*OUT_W-1:0]    column_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  last_out,
    input  logic                  tbl_wr_en_in,
    input  logic [BW-1:0]         tbl_wr_bank_in,
    input  logic [5:0]            tbl_wr_addr_in,
    input  logic [7:0]            tbl_wr_data_in,
    output logic                  tbl_wr_err_out
);

    localparam int PW = COEF_W + 9;
    localparam int TD = NBANK * 64;
    localparam int TW = BW + 6;

    localparam logic [7:0] LUMA [64] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24, 8'd40, 8'd51, 8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26, 8'd58, 8'd60, 8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40, 8'd57, 8'd69, 8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51, 8'd87, 8'd80, 8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68, 8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81, 8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    localparam logic [7:0] CHROMA [64] = '{
        8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
    };

`ifdef DEQUANT_SAT_EN
    localparam logic signed [PW-1:0] MAXV =
        {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV =
        {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    logic [7:0]         tbl_q [TD];
    logic [7:0]         tbl_d [TD];
    logic [2:0]         cnt_q, cnt_d;
    logic [BW-1:0]      bank_q, bank_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               err_q, err_d;
    logic [8*OUT_W-1:0] col_q, col_d;

    logic [8*OUT_W-1:0] prod_col;
    logic [BW-1:0]      bank_sel_c, bank_eff;
    logic [TW-1:0]      rd_idx, wr_idx;
    logic signed [PW-1:0] coef_ext, q_ext, prod;
    logic [OUT_W-1:0]   res;
    logic               in_xfer, wr_ok;

    assign ready_out = !valid_q || ready_in;
    assign in_xfer   = valid_in && ready_out;

    // Out-of-range bank selects fall back to the luma bank.
    assign bank_sel_c = (32'(bank_sel_in) >= NBANK) ? '0 : bank_sel_in;
    // Column 0 uses the bank presented with it; later columns use the latch.
    assign bank_eff   = (cnt_q == 3'd0) ? bank_sel_c : bank_q;

    always_comb begin
        prod_col = '0;
        rd_idx   = '0;
        coef_ext = '0;
        q_ext    = '0;
        prod     = '0;
        res      = '0;
        for (int r = 0; r < 8; r++) begin
            rd_idx   = {bank_eff, 3'(r), cnt_q};
            coef_ext = {{9{column_in[r*COEF_W+COEF_W-1]}},
                        column_in[r*COEF_W +: COEF_W]};
            q_ext    = {{(PW-8){1'b0}}, tbl_q[rd_idx]};
            prod     = coef_ext * q_ext;
`ifdef DEQUANT_SAT_EN
            if (prod > MAXV)
                res = MAXV[OUT_W-1:0];
            else if (prod < MINV)
                res = MINV[OUT_W-1:0];
            else
                res = prod[OUT_W-1:0];
`else
            res = prod[OUT_W-1:0];
`endif
            prod_col[r*OUT_W +: OUT_W] = res;
        end
    end

    // The block in flight owns its bank: writes to it mid-block are refused.
    always_comb begin
        wr_idx = {tbl_wr_bank_in, tbl_wr_addr_in};
        wr_ok  = tbl_wr_en_in
              && (tbl_wr_data_in != 8'd0)
              && (32'(tbl_wr_bank_in) < NBANK)
              && !((cnt_q != 3'd0) && (tbl_wr_bank_in == bank_q));
        err_d  = tbl_wr_en_in && !wr_ok;
        tbl_d  = tbl_q;
        if (wr_ok)
            tbl_d[wr_idx] = tbl_wr_data_in;
    end

    always_comb begin
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        valid_d = valid_q;
        last_d  = last_q;
        col_d   = col_q;
        if (in_xfer) begin
            cnt_d   = cnt_q + 3'd1;
            valid_d = 1'b1;
            col_d   = prod_col;
            last_d  = (cnt_q == 3'd7);
            if (cnt_q == 3'd0)
                bank_d = bank_sel_c;
        end else if (ready_in) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q   <= '0;
            bank_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            col_q   <= '0;
            for (int i = 0; i < TD; i++)
                tbl_q[i] <= (i / 64 == 1) ? CHROMA[6'(i % 64)]
                                          : LUMA[6'(i % 64)];
        end else begin
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
            col_q   <= col_d;
            tbl_q   <= tbl_d;
        end
    end

    assign column_out     = col_q;
    assign valid_out      = valid_q;
    assign last_out       = last_q;
    assign tbl_wr_err_out = err_q;

endmodule
